// File: rtl/laser_kbd_pkg.sv
// Shared definitions for the LASER310 scripted key injector: matrix indices,
// script entry layout, script base table and sequencer states.
package laser_kbd_pkg;

  localparam int KIDX_LSHIFT = 18;
  localparam int KIDX_CTRL   = 10;
  localparam int KIDX_CR     = 50;
  localparam int KIDX_SPACE  = 36;

  localparam int ENTRY_END_BIT   = 7;
  localparam int ENTRY_SHIFT_BIT = 6;
  localparam int ENTRY_IDX_MSB   = 5;
  localparam logic [7:0] ENTRY_END = 8'h80;

  localparam int ROM_AW = 8;
  localparam logic [ROM_AW-1:0] ADDR_LAST = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MOD,
    ST_PRESS,
    ST_GAP,
    ST_FINISH
  } seq_state_t;

  function automatic logic [ROM_AW-1:0] script_base(input logic [2:0] sel);
    logic [ROM_AW-1:0] base;
    case (sel)
      3'd0:    base = 8'h00;
      3'd1:    base = 8'h08;
      3'd2:    base = 8'h10;
      3'd3:    base = 8'h20;
      3'd4:    base = 8'h30;
      3'd5:    base = 8'h40;
      3'd6:    base = 8'h50;
      default: base = 8'hFD;
    endcase
    return base;
  endfunction

  // Active-low matrix pattern for one key, optionally with L-Shift held too.
  function automatic logic [63:0] key_mask(input logic [ENTRY_IDX_MSB:0] idx,
                                           input logic with_shift);
    logic [63:0] m;
    m = '1;
    m[idx] = 1'b0;
    if (with_shift) m[KIDX_LSHIFT] = 1'b0;
    return m;
  endfunction

  function automatic logic [7:0] key_entry(input int idx, input logic with_shift);
    return {1'b0, with_shift, 6'(idx)};
  endfunction

endpackage

// File: rtl/laser_key_script_rom.sv
// 256x8 synchronous script ROM; data appears one DLY_CLK after the address.
module laser_key_script_rom
  import laser_kbd_pkg::*;
(
  input  logic              DLY_CLK,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        data
);

  function automatic logic [7:0] rom_byte(input logic [ROM_AW-1:0] a);
    logic [7:0] b;
    case (a)
      // "RUN" + CR boot macro
      8'h00: b = 8'h05;
      8'h01: b = 8'h35;
      8'h02: b = 8'h20;
      8'h03: b = key_entry(KIDX_CR, 1'b0);
      8'h04: b = ENTRY_END;
      8'h08: b = 8'h45;
      8'h09: b = ENTRY_END;
      8'h10: b = 8'h13;
      8'h11: b = 8'h2C;
      8'h12: b = 8'h1A;
      8'h13: b = 8'h0D;
      8'h14: b = 8'h11;
      8'h15: b = key_entry(KIDX_CR, 1'b0);
      8'h16: b = ENTRY_END;
      8'h20: b = key_entry(KIDX_LSHIFT, 1'b1);
      8'h21: b = key_entry(KIDX_SPACE, 1'b0);
      8'h22: b = ENTRY_END;
      8'h30: b = key_entry(KIDX_CTRL, 1'b0);
      8'h31: b = 8'h05;
      8'h32: b = ENTRY_END;
      8'h40: b = ENTRY_END;
      8'h50: b = 8'h3F;
      8'h51: b = 8'h00;
      8'h52: b = ENTRY_END;
      // Tail script with no END byte; the sequencer stops at the last address.
      8'hFD: b = 8'h01;
      8'hFE: b = key_entry(KIDX_LSHIFT, 1'b1);
      8'hFF: b = 8'h7F;
      default: b = ENTRY_END;
    endcase
    return b;
  endfunction

  always_ff @(posedge DLY_CLK) begin
    data <= rom_byte(addr);
  end

endmodule

// File: rtl/laser_key_sequencer.sv
// Plays keystroke scripts from the script ROM into an active-low 64-key
// injection matrix, yielding to the physical keyboard whenever it is in use.
module laser_key_sequencer
  import laser_kbd_pkg::*;
#(
  parameter int HOLD_TICKS = 8192,
  parameter int GAP_TICKS  = 8192,
  parameter int MOD_TICKS  = 1024,
  parameter int CNT_W      = 16
) (
  input  logic        DLY_CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [2:0]  SCRIPT_SEL,
  input  logic        ABORT,
  input  logic        PS2_ACTIVE,
  output logic [63:0] INJ_KEY,
  output logic        BUSY,
  output logic        DONE,
  output logic        ABORTED
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] MOD_LAST  = CNT_W'(MOD_TICKS - 1);

  seq_state_t state, next_state;
  logic [CNT_W-1:0] timer, next_timer;
  logic [ROM_AW-1:0] addr, next_addr;
  logic entry_shift, next_entry_shift;
  logic [ENTRY_IDX_MSB:0] entry_idx, next_entry_idx;
  logic [63:0] inj_q, next_inj;
  logic busy_q, done_q, aborted_q, next_aborted;
  logic [7:0] rom_data;

  laser_key_script_rom script_rom (
    .DLY_CLK (DLY_CLK),
    .addr    (addr),
    .data    (rom_data)
  );

  always_ff @(posedge DLY_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      timer       <= '0;
      addr        <= '0;
      entry_shift <= 1'b0;
      entry_idx   <= '0;
      inj_q       <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= next_timer;
      addr        <= next_addr;
      entry_shift <= next_entry_shift;
      entry_idx   <= next_entry_idx;
      inj_q       <= next_inj;
      busy_q      <= (next_state != ST_IDLE);
      done_q      <= (next_state == ST_FINISH);
      aborted_q   <= next_aborted;
    end
  end

  // Timed states hold their timer at zero while the physical keyboard is
  // active, so each one replays its full duration once the user lets go.
  always_comb begin
    next_state       = state;
    next_timer       = timer;
    next_addr        = addr;
    next_entry_shift = entry_shift;
    next_entry_idx   = entry_idx;
    next_aborted     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START && !ABORT) begin
          next_addr  = script_base(SCRIPT_SEL);
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: next_state = ST_DECODE;
      ST_DECODE: begin
        next_entry_shift = rom_data[ENTRY_SHIFT_BIT];
        next_entry_idx   = rom_data[ENTRY_IDX_MSB:0];
        next_timer       = '0;
        if (rom_data[ENTRY_END_BIT])        next_state = ST_FINISH;
        else if (rom_data[ENTRY_SHIFT_BIT]) next_state = ST_MOD;
        else                                next_state = ST_PRESS;
      end
      ST_MOD: begin
        if (PS2_ACTIVE) begin
          next_timer = '0;
        end else if (timer == MOD_LAST) begin
          next_timer = '0;
          next_state = ST_PRESS;
        end else begin
          next_timer = timer + 1'b1;
        end
      end
      ST_PRESS: begin
        if (PS2_ACTIVE) begin
          next_timer = '0;
        end else if (timer == HOLD_LAST) begin
          next_timer = '0;
          next_state = ST_GAP;
        end else begin
          next_timer = timer + 1'b1;
        end
      end
      ST_GAP: begin
        if (PS2_ACTIVE) begin
          next_timer = '0;
        end else if (timer == GAP_LAST) begin
          next_timer = '0;
          if (addr == ADDR_LAST) begin
            next_state = ST_FINISH;
          end else begin
            next_addr  = addr + 1'b1;
            next_state = ST_FETCH;
          end
        end else begin
          next_timer = timer + 1'b1;
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase

    if (ABORT && state != ST_IDLE) begin
      next_state   = ST_IDLE;
      next_timer   = '0;
      next_aborted = 1'b1;
    end
  end

  // The matrix pattern follows the upcoming state and entry so it is glitch-free.
  always_comb begin
    next_inj = '1;
    if (!PS2_ACTIVE) begin
      case (next_state)
        ST_MOD:   next_inj = key_mask(6'(KIDX_LSHIFT), 1'b0);
        ST_PRESS: next_inj = key_mask(next_entry_idx, next_entry_shift);
        default:  next_inj = '1;
      endcase
    end
  end

  assign INJ_KEY = inj_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ABORTED = aborted_q;

endmodule

// File: doc/laser_key_sequencer.md
Name: laser_key_sequencer

Overview:
- Scripted key-injection controller for the LASER310 keyboard matrix.
- On a START request it reads a keystroke script from an internal ROM and presses and releases the matching matrix keys with timing the Z80 scan loop can detect. Typical scripts are boot macros ("RUN"+CR) and cassette-load strings.
- Output is a 64-bit active-low injection matrix. The top level ANDs it bitwise with the PS/2-derived matrix before the row/column read logic.
- Arbitrates matrix access against the physical keyboard: the physical keyboard always wins.

Parameters:
- HOLD_TICKS, 8192, DLY_CLK cycles a key is held (about 52 ms at 156.25 kHz; longer than one 50 Hz scan).
- GAP_TICKS, 8192, DLY_CLK cycles with all injected keys released between entries.
- MOD_TICKS, 1024, DLY_CLK cycles SHIFT is held alone before the shifted key.
- CNT_W, 16, timer width. Must satisfy 2^CNT_W > max(HOLD_TICKS, GAP_TICKS, MOD_TICKS).

Ports:
- DLY_CLK  in  1  block clock, 0.15625 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- SCRIPT_SEL  in  3  script number, sampled together with START.
- ABORT  in  1  level; cancels any running script.
- PS2_ACTIVE  in  1  high while any physical key is down (KEY_PRESSED, synchronised to DLY_CLK by the top level).
- INJ_KEY  out  64  injected matrix, active-low; bit = row*8+col in the existing matrix numbering.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on normal script completion.
- ABORTED  out  1  one-cycle pulse when ABORT ends a running script.

Behaviour:
- Script entry, 8 bits:
  - bit7 END: stop, no key.
  - bit6 SHIFT: also press L-Shift, matrix bit 18.
  - bits5:0: matrix index.
- Reset (asynchronous): state IDLE, INJ_KEY = all ones, BUSY = DONE = ABORTED = 0, timer = 0, ROM address = 0.
- The ROM is synchronous with 1-cycle read latency. Address width is 8 bits.
- States and transitions:
  - IDLE: if START=1, load address = BASE[SCRIPT_SEL] and go to FETCH. START is ignored in every other state.
  - FETCH: ROM address presented; go to DECODE.
  - DECODE: latch the entry.
    - END=1 → FINISH.
    - SHIFT=1 → MOD.
    - otherwise → PRESS.
    - Timer cleared on leaving DECODE.
  - MOD: INJ_KEY[18] = 0 only. After MOD_TICKS cycles → PRESS.
  - PRESS: INJ_KEY[idx] = 0, plus bit 18 if SHIFT. After HOLD_TICKS cycles → GAP.
  - GAP: INJ_KEY all ones. After GAP_TICKS cycles, address+1 → FETCH.
  - FINISH: DONE = 1 for one cycle → IDLE.
- Latency: first key is low exactly 3 cycles after the edge that samples START (FETCH, DECODE, then PRESS).
- INJ_KEY is registered and is a function of state and latched entry only.
- Arbitration: while PS2_ACTIVE=1 in MOD, PRESS or GAP:
  - INJ_KEY is forced to all ones and the timer is held at 0.
  - On deassertion the same state restarts its full duration.
  - In FETCH/DECODE, PS2_ACTIVE has no effect.
- ABORT=1 in any non-IDLE state:
  - next cycle goes to IDLE with INJ_KEY all ones and ABORTED = 1 for one cycle; no DONE.
  - ABORT beats a same-cycle timer expiry or END.
  - ABORT in IDLE does nothing and blocks START in that cycle.
- Address wrap: if GAP completes at address 8'hFF, go to FINISH instead of wrapping (treated as an implicit END).
- An index of 18 with SHIFT set pulls the same bit low; no conflict.
- Indices 0..63 are all legal.

Decomposition:
- Package laser_kbd_pkg holds:
  - matrix index constants: KIDX_LSHIFT=18, KIDX_CTRL=10, KIDX_CR=50, KIDX_SPACE=36;
  - entry field positions and END code 8'h80;
  - the 8-entry BASE address table;
  - the state enum.
- One sub-module, laser_key_script_rom: 256x8 synchronous ROM containing the script bytes.

Test Plan (HOLD_TICKS=4, GAP_TICKS=3, MOD_TICKS=2; script 0 at BASE 0 = 05,35,20,32,80, i.e. "RUN"+CR):
- START, SCRIPT_SEL=0 at cycle 0 → INJ_KEY[5]=0 for cycles 3-6; all ones for 7-9; then keys 53, 32, 50 in turn, each 4 low / 3 high; DONE pulse once; BUSY falls with DONE.
- Script entry 0x45 (SHIFT+R) → bit18 low alone for 2 cycles, then bits 18 and 5 both low for 4 cycles, then all ones.
- PS2_ACTIVE high for 10 cycles during the 2nd PRESS cycle → INJ_KEY all ones during that window; after release, the key is held a full 4 cycles; total DONE delay grows by 10+1.
- ABORT asserted in GAP → next cycle IDLE, ABORTED=1, DONE never pulses, INJ_KEY all ones; a START 1 cycle later is accepted.
- START pulses while BUSY, and RESET_N low mid-PRESS → extra START ignored; reset forces INJ_KEY=all ones and BUSY=0 asynchronously.
- Script at BASE 8'hFD with no END byte → keys at FD, FE, FF played, then DONE; address never wraps to 0.
